// File: rtl/seg_scan.sv
`timescale 1ns/1ps
// 4-digit 7-segment scanner: double-buffered load (ack 1 cycle later), BLANK_CYC dark cycles per digit change,
// registered outputs, no backpressure (load always accepted). Optional leading-zero blanking via SEG_LZB_EN.
module seg_scan #(
   parameter int BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  sel,
   input  logic [15:0] din,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic        ack,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   typedef enum logic {BLANK, ACTIVE} state_t;

   localparam logic [7:0] LAST = 8'(BLANK_CYC - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [1:0]  sel_q, sel_q_nx;
   logic [15:0] shadow, shadow_nx, display, display_nx;
   logic [3:0]  shadow_dp, shadow_dp_nx, display_dp, display_dp_nx;
   logic        pending, pending_nx;
   logic        ack_nx;
   logic [3:0]  an_nx;
   logic [6:0]  seg_nx;
   logic        dp_nx;

   logic [3:0]  nib;
   logic        blank_lz;
   logic [6:0]  lit_seg;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      nib      = display[3:0];
      blank_lz = 1'b0;
      case (sel_q)
         2'd0: nib = display[3:0];
         2'd1: nib = display[7:4];
         2'd2: nib = display[11:8];
         default: nib = display[15:12];
      endcase
`ifdef SEG_LZB_EN
      // a digit goes dark when it and every digit to its left are zero; digit 0 always shows
      case (sel_q)
         2'd0: blank_lz = 1'b0;
         2'd1: blank_lz = (display[15:4] == 12'h000);
         2'd2: blank_lz = (display[15:8] == 8'h00);
         default: blank_lz = (display[15:12] == 4'h0);
      endcase
`else
      blank_lz = 1'b0;
`endif
      lit_seg = blank_lz ? 7'h7F : hex7(nib);
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      sel_q_nx      = sel_q;
      shadow_nx     = shadow;
      shadow_dp_nx  = shadow_dp;
      display_nx    = display;
      display_dp_nx = display_dp;
      pending_nx    = pending | load;
      ack_nx        = load;
      an_nx         = 4'hF;
      seg_nx        = 7'h7F;
      dp_nx         = 1'b1;

      if (load) begin
         shadow_nx    = din;
         shadow_dp_nx = dp_in;
      end

      if (sel != sel_q) begin
         sel_q_nx = sel;
         cnt_nx   = 8'd0;
         state_nx = BLANK;
         // transfer uses the pre-edge shadow; a coincident load stays pending
         if (pending) begin
            display_nx    = shadow;
            display_dp_nx = shadow_dp;
            pending_nx    = load;
         end
      end else if (state == BLANK) begin
         if (cnt == LAST) begin
            state_nx = ACTIVE;
            an_nx    = ~(4'b0001 << sel_q);
            seg_nx   = lit_seg;
            dp_nx    = ~display_dp[sel_q];
         end else begin
            cnt_nx = cnt + 8'd1;
         end
      end else begin
         an_nx  = ~(4'b0001 << sel_q);
         seg_nx = lit_seg;
         dp_nx  = ~display_dp[sel_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BLANK;
         cnt        <= 8'd0;
         sel_q      <= 2'd0;
         shadow     <= 16'h0000;
         shadow_dp  <= 4'h0;
         display    <= 16'h0000;
         display_dp <= 4'h0;
         pending    <= 1'b0;
         ack        <= 1'b0;
         an         <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         sel_q      <= sel_q_nx;
         shadow     <= shadow_nx;
         shadow_dp  <= shadow_dp_nx;
         display    <= display_nx;
         display_dp <= display_dp_nx;
         pending    <= pending_nx;
         ack        <= ack_nx;
         an         <= an_nx;
         seg        <= seg_nx;
         dp         <= dp_nx;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
`timescale 1ns/1ps
// Scoreboard bench for seg_scan: stimulus queues expected lit digits and ack cycles, a negedge monitor checks them.
module tb_seg_scan;
   localparam int BLANK_CYC = 4;

`ifdef SEG_LZB_EN
   localparam logic [6:0] ZHI = 7'h7F;
`else
   localparam logic [6:0] ZHI = 7'b1000000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic [15:0] din = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic        ack;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         blank;
   } lit_t;

   lit_t lit_q[$];
   int   ack_q[$];
   lit_t cur;
   logic have_cur = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   blank_run = 0;
   logic rst_prev = 1'b1;

   seg_scan #(.BLANK_CYC(BLANK_CYC)) dut (
      .clk(clk), .rst(rst), .sel(sel), .din(din), .dp_in(dp_in), .load(load),
      .ack(ack), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= rst;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst_prev) begin
         chk("rst_an", int'(an), 'hF);
         chk("rst_seg", int'(seg), 'h7F);
         chk("rst_dp", int'(dp), 1);
         chk("rst_ack", int'(ack), 0);
         blank_run = 1;
         have_cur  = 1'b0;
      end else begin
         if (ack) begin
            if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
            else chk("ack_cycle", cyc, ack_q.pop_front());
         end
         if (an == 4'hF) begin
            chk("blank_seg", int'(seg), 'h7F);
            chk("blank_dp", int'(dp), 1);
            blank_run++;
         end else begin
            if (blank_run > 0) begin
               if (lit_q.size() == 0) begin
                  chk("lit_unexpected", int'(an), 'hF);
                  have_cur = 1'b0;
               end else begin
                  cur      = lit_q.pop_front();
                  have_cur = 1'b1;
                  chk("blank_len", blank_run, cur.blank);
               end
               blank_run = 0;
            end
            if (have_cur) begin
               chk("lit_an", int'(an), int'(cur.an));
               chk("lit_seg", int'(seg), int'(cur.seg));
               chk("lit_dp", int'(dp), int'(cur.dp));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_lit(input logic [3:0] a, input logic [6:0] s, input logic d, input int b);
      lit_t e;
      e.an = a; e.seg = s; e.dp = d; e.blank = b;
      lit_q.push_back(e);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      din = d; dp_in = p; load = 1'b1;
      ack_q.push_back(cyc + 1);
      tick(1);
      load = 1'b0;
   endtask

   task automatic show(input logic [1:0] s, input logic [3:0] a, input logic [6:0] sg, input logic d);
      expect_lit(a, sg, d, BLANK_CYC);
      sel = s;
      tick(BLANK_CYC + 4);
   endtask

   initial begin
      // reset, then digit 0 shows "0" after BLANK_CYC dark cycles
      tick(3);
      expect_lit(4'b1110, 7'b1000000, 1'b1, BLANK_CYC);
      rst = 1'b0;
      tick(10);

      // 12AF with dp on digit 2
      do_load(16'h12AF, 4'b0100);
      tick(1);
      show(2'd1, 4'b1101, 7'b0001000, 1'b1);
      show(2'd2, 4'b1011, 7'b0100100, 1'b0);
      show(2'd3, 4'b0111, 7'b1111001, 1'b1);
      show(2'd0, 4'b1110, 7'b0001110, 1'b1);

      // back-to-back loads mid-digit: F stays lit, last load wins at next change
      do_load(16'h1111, 4'h0);
      do_load(16'h2222, 4'h0);
      tick(3);
      show(2'd1, 4'b1101, 7'b0100100, 1'b1);

      // sel changes again on the second blank cycle
      expect_lit(4'b0111, 7'b0100100, 1'b1, BLANK_CYC + 2);
      sel = 2'd2;
      tick(2);
      sel = 2'd3;
      tick(10);

      // load coincident with a digit change: display takes the older shadow
      do_load(16'h3456, 4'b0001);
      tick(1);
      din = 16'h789A; dp_in = 4'h0; load = 1'b1; sel = 2'd0;
      ack_q.push_back(cyc + 1);
      expect_lit(4'b1110, 7'b0000010, 1'b0, BLANK_CYC);
      tick(1);
      load = 1'b0;
      tick(BLANK_CYC + 3);
      show(2'd1, 4'b1101, 7'b0010000, 1'b1);

      // 0070: leading zeros depend on build
      do_load(16'h0070, 4'h0);
      tick(1);
      show(2'd3, 4'b0111, ZHI, 1'b1);
      show(2'd2, 4'b1011, ZHI, 1'b1);
      show(2'd1, 4'b1101, 7'b1111000, 1'b1);
      show(2'd0, 4'b1110, 7'b1000000, 1'b1);

      // reset while ACTIVE with a pending load; load during reset is dropped
      do_load(16'hBEEF, 4'hF);
      tick(2);
      rst = 1'b1;
      tick(1);
      din = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
      tick(1);
      load = 1'b0;
      expect_lit(4'b1110, 7'b1000000, 1'b1, BLANK_CYC);
      rst = 1'b0;
      tick(BLANK_CYC + 4);
      show(2'd1, 4'b1101, ZHI, 1'b1);
      show(2'd2, 4'b1011, ZHI, 1'b1);
      show(2'd3, 4'b0111, ZHI, 1'b1);

      tick(5);
      chk("lit_q_empty", lit_q.size(), 0);
      chk("ack_q_empty", ack_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter BLANK_CYC, default 4, meaning: all-anodes-off cycles inserted at every digit change (legal range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 sel  input  2  digit select from the upstream free-running counter MSBs.
REQ-005 din  input  16  four hex nibbles; din[3:0] is digit 0 (rightmost).
REQ-006 dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-007 load  input  1  strobe; captures din/dp_in into the shadow register.
REQ-008 ack  output  1  one-cycle pulse acknowledging a load.
REQ-009 an  output  4  anode enables, active-low; an[i] = digit i.
REQ-010 seg  output  7  segments a..g, active-low; seg[0] = a, seg[6] = g.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Internal state: shadow (16b + 4b dp), display (16b + 4b dp), pending flag, sel_q (2b), FSM {BLANK, ACTIVE}, blank counter cnt (8b).
REQ-013 load=1 at an edge writes shadow <= {din, dp_in}, sets pending, and drives ack=1 for exactly the following cycle; back-to-back loads give back-to-back ack pulses; last load wins.
REQ-014 Digit change: an edge where sel != sel_q sets sel_q <= sel, cnt <= 0, state <= BLANK, an <= 4'b1111, seg <= 7'h7F, dp <= 1.
REQ-015 At that same edge, if pending=1, display <= shadow and pending clears; display never changes at any other time (no tearing mid-digit).
REQ-016 Same-edge load and digit change: transfer copies the pre-edge shadow; the new load lands in shadow and pending remains 1.
REQ-017 BLANK: cnt increments each edge; outputs held off; at the edge where cnt == BLANK_CYC-1, state <= ACTIVE and outputs are driven for digit sel_q; anodes are therefore off exactly BLANK_CYC cycles.
REQ-018 A sel change during BLANK restarts cnt at 0 with the new sel_q (REQ-014 applies, including the transfer).
REQ-019 ACTIVE: an = ~(4'b0001 << sel_q); seg = hex decode of display nibble sel_q (0-9, A, b, C, d, E, F, standard Basys-style glyphs); dp = ~display_dp[sel_q]; outputs are refreshed every edge while ACTIVE.
REQ-020 All outputs are registered; there is no combinational path from any input to any output.
REQ-021 Exactly one anode is low in ACTIVE; no anode is ever low in BLANK.

Reset
REQ-022 While rst=1 at an edge: state <= BLANK, cnt <= 0, sel_q <= 0, shadow <= 0, display <= 0, pending <= 0, ack <= 0, an <= 4'b1111, seg <= 7'h7F, dp <= 1.
REQ-023 rst dominates load and sel in the same cycle; a load coincident with rst is discarded and not acked.
REQ-024 After reset release with sel constant at 0, digit 0 is lit showing "0" after BLANK_CYC cycles.

Configuration
REQ-025 Macro SEG_LZB_EN: when defined, digits 3..1 output seg = 7'h7F if their nibble and all higher nibbles of display are 0, and digit 0 is always decoded; dp and anode timing are unaffected.
REQ-026 Without SEG_LZB_EN, every digit is decoded regardless of value.

Verification
REQ-027 Reset, then sel held at 0 with BLANK_CYC=4 -> an=1111 for 4 cycles, then an=1110, seg=7'b1000000 ("0").
REQ-028 load din=16'h12AF, dp_in=4'b0100 with sel stepping 0,1,2,3 -> ack one cycle after load; digits show F, A, 2 (dp=0), 1, each preceded by exactly 4 blank cycles.
REQ-029 load 16'h1111 then 16'h2222 on consecutive cycles mid-digit -> display unchanged until next sel change, then shows 2222; two ack pulses.
REQ-030 sel changes during cycle 2 of BLANK -> blank counter restarts; anodes off 4 further cycles; new digit lit.
REQ-031 SEG_LZB_EN defined, display 16'h0070 -> digit3 and digit2 blank, digit1 "7", digit0 "0"; without macro -> "0070".
REQ-032 rst asserted in ACTIVE with pending load -> next edge all outputs off, ack=0, pending cleared; shows "0000" after release.
